// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: the access size codes, the
// FSM state encoding, the default memory geometry, and read-data helpers.
package dmem_pkg;

    localparam int DMEM_AW = 12;
    localparam int DMEM_DW = 64;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Zero-extend the low 1/2/4/8 bytes of the memory read data.
    function automatic logic [DMEM_DW-1:0] size_mask(input logic [1:0] size,
                                                     input logic [DMEM_DW-1:0] data);
        logic [DMEM_DW-1:0] m;
        m = '0;
        case (size)
            SZ_B:    m[7:0]  = data[7:0];
            SZ_H:    m[15:0] = data[15:0];
            SZ_W:    m[31:0] = data[31:0];
            default: m       = data;
        endcase
        return m;
    endfunction

    // True when the address is not a multiple of the access size.
    function automatic logic misaligned(input logic [2:0] addr_lo,
                                        input logic [1:0] size);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = |addr_lo[1:0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational round-robin picker: the winner is the first asserted request
// after the pointer position, wrapping. The pointer itself lives in the parent.
module dmem_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    logic          found;
    logic [PW-1:0] pos;

    // Scan NREQ positions starting just after the pointer; first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            pos = PW'((int'(ptr) + i) % NREQ);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates NREQ requesters onto a single-ported byte-addressed data memory.
// Each access takes three cycles (grant, memory access, response); only one
// transaction is in flight. Optional alignment checking is enabled by defining
// DMEM_ARB_ALIGN_CHECK_EN, which adds the err output and suppresses misaligned
// accesses instead of passing them to memory.
//
// state  | meaning
// IDLE   | arbitrate; gnt is the round-robin winner, request latched on the edge
// ACCESS | mem_* driven from latched request; write commits / read captured
// RESP   | rvalid (and err) strobe for the latched requester
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = DMEM_AW,
    parameter int DW   = DMEM_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic [NREQ*2-1:0] req_size,
    input  logic [NREQ-1:0]   req_we,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    output logic [NREQ-1:0]   err,
`endif
    output logic [DW-1:0]     rdata,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_dataw,
    output logic [1:0]        mem_word,
    output logic              mem_rw,
    input  logic [DW-1:0]     mem_datar
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_gnt;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;
    logic [1:0]      lat_size;
    logic            lat_we;
    logic [PW-1:0]   lat_idx;
    logic            mem_ok;
    logic            take;

    dmem_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic lat_mis;
    assign mem_ok = !lat_mis;
`else
    assign mem_ok = 1'b1;
`endif

    assign take = (state == IDLE) && (|req);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state; the sequence is fixed once a request is taken.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Latch the winning request, advance the pointer, and capture read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= PW'(NREQ - 1);
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_size  <= '0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            rdata     <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            lat_mis   <= 1'b0;
`endif
        end else begin
            if (take) begin
                ptr       <= pick_idx;
                lat_idx   <= pick_idx;
                lat_addr  <= req_addr[pick_idx*AW +: AW];
                lat_wdata <= req_wdata[pick_idx*DW +: DW];
                lat_size  <= req_size[pick_idx*2 +: 2];
                lat_we    <= req_we[pick_idx];
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                lat_mis   <= misaligned(req_addr[pick_idx*AW +: 3],
                                        req_size[pick_idx*2 +: 2]);
`endif
            end
            if (state == ACCESS) begin
                if (!lat_we && mem_ok) rdata <= size_mask(lat_size, mem_datar);
                else                   rdata <= '0;
            end
        end
    end

    // Memory side: address/data/size hold the latched request; the write
    // enable is decoded from state so it drops as soon as reset asserts.
    always_comb begin
        mem_addr  = lat_addr;
        mem_dataw = lat_wdata;
        mem_word  = lat_size;
        mem_rw    = (state == ACCESS) && lat_we && mem_ok;
    end

    // Requester side strobes: grant only while idle, response in RESP.
    always_comb begin
        gnt    = (state == IDLE && !rst) ? pick_gnt : '0;
        rvalid = '0;
        if (state == RESP) rvalid[lat_idx] = 1'b1;
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    // Misalignment error reported alongside the response strobe.
    always_comb begin
        err = '0;
        if (state == RESP && lat_mis) err[lat_idx] = 1'b1;
    end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates up to NREQ requesters (load/store unit, debug/loader port) onto the single-ported 4 KiB byte-addressed data memory.
- Sequences each access over three cycles: grant, memory access, response.
- Owns the memory write strobe.
- Registers and size-masks the memory's combinational read data.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 12, byte address width.
- DW, 64, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- req  in  NREQ  per-requester request; held until the matching gnt bit.
- req_addr  in  NREQ*AW  packed byte addresses; requester i uses slice [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- req_size  in  NREQ*2  packed size: 00 byte, 01 half, 10 word, 11 double.
- req_we  in  NREQ  1 = write, 0 = read.
- gnt  out  NREQ  one-hot; request accepted at this posedge.
- rvalid  out  NREQ  one-hot, one-cycle response strobe.
- rdata  out  DW  read data, valid when any rvalid bit is set.
- mem_addr  out  AW  to memory address.
- mem_dataw  out  DW  to memory write data.
- mem_word  out  2  to memory size.
- mem_rw  out  1  to memory write enable.
- mem_datar  in  DW  from memory; combinational read data.

Behaviour:
- Reset values: state IDLE, rr pointer NREQ-1 (requester 0 wins first). gnt=0, rvalid=0, rdata=0, mem_addr=0, mem_dataw=0, mem_word=0, mem_rw=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - gnt = one-hot winner among asserted req bits. gnt is combinational and only asserted in IDLE.
  - Winner = first asserted index after the rr pointer, wrapping.
  - At the posedge with gnt set: latch addr/wdata/size/we/index, move the pointer to the winner, go to ACCESS.
  - No req: stay in IDLE.
- ACCESS:
  - mem_* outputs are driven from the latched registers.
  - mem_rw = latched we, high for exactly this one cycle; the write commits at the posedge that ends ACCESS.
  - On a read, capture mem_datar into rdata at that edge.
  - Go to RESP.
- RESP:
  - rvalid[index]=1 for one cycle. rdata holds the read result; it is 0 after a write.
  - Go to IDLE.
- Read masking, zero-extended: byte keeps [7:0], half keeps [15:0], word keeps [31:0], double keeps all 64 bits.
- mem_rw=0 in IDLE and RESP. mem_addr/mem_dataw/mem_word hold their last latched values outside ACCESS.
- Timing: latency is req (in IDLE) to rvalid = 2 cycles after the grant edge; throughput is one access per 3 cycles; at most one transaction in flight.
- Simultaneous requests: round-robin; no requester is starved beyond NREQ-1 intervening grants.
- req dropped before gnt: not served. req dropped after gnt: the transaction still completes.
- req held high through RESP: re-arbitrated on return to IDLE, with the pointer favouring the others.
- Address wrap: addresses are passed unmodified; multi-byte accesses crossing 0xFFF wrap modulo 4096.
- Reset mid-ACCESS: mem_rw drops immediately on rst assertion; the in-flight write is not committed and no rvalid is issued.

Optional Feature:
- Macro DMEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - Adds output err [NREQ-1:0], reset 0.
  - A misaligned request (addr not a multiple of 2^size) is still granted.
  - ACCESS keeps mem_rw=0 and no capture occurs.
  - In RESP, rvalid and err assert together for the index; rdata=0.
- Undefined: err port absent; misaligned requests are passed to memory unchanged.

Decomposition:
- Package dmem_pkg:
  - size constants SZ_B/SZ_H/SZ_W/SZ_D;
  - state encoding IDLE/ACCESS/RESP;
  - DMEM_AW=12, DMEM_DW=64;
  - a function for size-based read masking.
- One sub-module, dmem_rr_pick:
  - combinational round-robin winner from req and pointer;
  - the pointer register stays in the parent.

Test Plan:
- Single write then read, requester 0: write addr 0x010, size 11, data 0x1122334455667788. Then a byte read at 0x013 returns rdata=0x55 with rvalid[0] 2 cycles after gnt.
- Read masking: half read at 0x010 returns 0x7788; word read returns 0x55667788, upper bits zero.
- Contention: req=2'b11 held continuously. Grants alternate 0,1,0,1; each rvalid goes to the matching index; gnt never asserts outside IDLE.
- Wrap: double write 0xAABBCCDDEEFF0011 at 0xFFC. Byte read at 0x000 returns 0xDD; byte read at 0xFFF returns 0xEE.
- Reset mid-ACCESS: write 0xFF to 0x020, assert rst during ACCESS. mem_rw falls immediately, a later read of 0x020 returns the prior value, no rvalid is issued, and requester 0 wins first afterwards.
- With DMEM_ARB_ALIGN_CHECK_EN: word write at 0x002. err[0] and rvalid[0] assert together, mem_rw stays 0 throughout, and memory is unchanged.
